// File: rtl/logic_clk_pkg.sv
// -----------------------------------------------------------------------------
// logic_clk_pkg
// Shared encodings for the debug clock sequencer: the command opcodes issued
// by the JTAG instruction decoder and the sequencer state enum.
// -----------------------------------------------------------------------------
package logic_clk_pkg;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_RUN  = 2'b01,
        OP_HALT = 2'b10,
        OP_STEP = 2'b11
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_HALTED = 2'b00,
        ST_RUN    = 2'b01,
        ST_STEP   = 2'b10
    } state_e;

endpackage

// File: rtl/clk_en_retime.sv
// -----------------------------------------------------------------------------
// clk_en_retime
// Falling-edge retiming flop for the clock-gate enable. Because it only
// updates on falling clk, its output is stable for the whole high phase,
// which keeps the downstream AND-type clock gate glitch-free. Kept as its own
// module so timing constraints can target it directly.
//
// Ports:
//   clk       in   system clock (flop triggers on the falling edge)
//   rst_n     in   synchronous active-low reset, sampled on the falling edge
//   en_i      in   enable from the rising-edge domain
//   clk_en_o  out  retimed enable for the clock gate
// -----------------------------------------------------------------------------
module clk_en_retime (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic clk_en_o
);

    logic clk_en_q;

    always_ff @(negedge clk) begin
        if (!rst_n) begin
            clk_en_q <= 1'b0;
        end else begin
            clk_en_q <= en_i;
        end
    end

    assign clk_en_o = clk_en_q;

endmodule

// File: rtl/logic_clk_ctrl.sv
// -----------------------------------------------------------------------------
// logic_clk_ctrl
// Debug clock sequencer. Takes RUN / HALT / STEP commands and produces the
// enable for the clock gate feeding the logic under test. Supports free run,
// halt, N-cycle stepping, breakpoint stop and a count of delivered pulses.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   synchronous active-low reset
//   cmd_valid  in   command present
//   cmd_ready  out  command can be accepted (low while stepping)
//   cmd_op     in   00 NOP, 01 RUN, 10 HALT, 11 STEP
//   cmd_count  in   STEP length in gated cycles
//   brk        in   breakpoint request from the logic under test
//   clk_en     out  clock-gate enable, changes on falling clk only
//   halted     out  high while halted
//   step_done  out  one-cycle pulse when a STEP ends (normally or by brk)
//   brk_hit    out  sticky: a breakpoint stopped RUN or STEP
//   cycle_cnt  out  number of gated pulses delivered (wraps)
// -----------------------------------------------------------------------------
module logic_clk_ctrl
    import logic_clk_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             brk,
    output logic             clk_en,
    output logic             halted,
    output logic             step_done,
    output logic             brk_hit,
    output logic [CNT_W-1:0] cycle_cnt
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] step_left_q, step_left_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic             en_q, en_d;
    logic             step_done_q, step_done_d;
    logic             brk_hit_q, brk_hit_d;

    cmd_op_e op;
    logic    cmd_acc;

    assign op      = cmd_op_e'(cmd_op);
    assign cmd_acc = cmd_valid & cmd_ready;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    // NOTE: reset is synchronous, so it only takes effect on a rising edge;
    // every flop here is a plain register, so all of them get a reset value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_HALTED;
            step_left_q <= '0;
            cycle_cnt_q <= '0;
            en_q        <= 1'b0;
            step_done_q <= 1'b0;
            brk_hit_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_left_q <= step_left_d;
            cycle_cnt_q <= cycle_cnt_d;
            en_q        <= en_d;
            step_done_q <= step_done_d;
            brk_hit_q   <= brk_hit_d;
        end
    end

    // Next-state logic.
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        step_left_d = step_left_q;
        step_done_d = 1'b0;
        brk_hit_d   = brk_hit_q;

        if (cmd_acc && (op == OP_RUN || op == OP_STEP)) begin
            brk_hit_d = 1'b0;
        end

        unique case (state_q)
            ST_HALTED: begin
                // brk is deliberately ignored here.
                if (cmd_acc) begin
                    case (op)
                        OP_RUN: state_d = ST_RUN;
                        OP_STEP: begin
                            if (cmd_count != '0) begin
                                state_d     = ST_STEP;
                                step_left_d = cmd_count;
                            end else begin
                                step_done_d = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            ST_RUN: begin
                // Breakpoint beats any command on the same edge; that
                // command is still acknowledged but dropped.
                if (brk) begin
                    state_d   = ST_HALTED;
                    brk_hit_d = 1'b1;
                end else if (cmd_acc) begin
                    case (op)
                        OP_HALT: state_d = ST_HALTED;
                        OP_STEP: begin
                            if (cmd_count != '0) begin
                                state_d     = ST_STEP;
                                step_left_d = cmd_count;
                            end else begin
                                step_done_d = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            ST_STEP: begin
                // en_q is high throughout STEP, so every cycle here is an
                // enabled cycle. The pulse on the edge that leaves STEP still
                // happens because clk_en only drops on the following fall.
                step_left_d = step_left_q - CNT_W'(1);
                if (brk) begin
                    state_d     = ST_HALTED;
                    step_done_d = 1'b1;
                    brk_hit_d   = 1'b1;
                end else if (step_left_q == CNT_W'(1)) begin
                    state_d     = ST_HALTED;
                    step_done_d = 1'b1;
                end
            end

            default: state_d = ST_HALTED;
        endcase
    end

    // en_q tracks the next state so the gate opens one edge after accept.
    always_comb begin
        en_d        = (state_d != ST_HALTED);
        cycle_cnt_d = clk_en ? cycle_cnt_q + CNT_W'(1) : cycle_cnt_q;
    end

    // Output logic.
    always_comb begin
        cmd_ready = (state_q != ST_STEP);
        halted    = (state_q == ST_HALTED);
        step_done = step_done_q;
        brk_hit   = brk_hit_q;
        cycle_cnt = cycle_cnt_q;
    end

    clk_en_retime u_clk_en_retime (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     (en_q),
        .clk_en_o (clk_en)
    );

endmodule

// File: tb/tb_logic_clk_ctrl.sv
// -----------------------------------------------------------------------------
// tb_logic_clk_ctrl
// Scoreboard bench for logic_clk_ctrl. A 16-bit and a 4-bit instance share
// stimulus. The reference model treats the sequencer as a pulse budget:
// 0 = halted, -1 = unlimited (run), N > 0 = N pulses still owed (step).
// -----------------------------------------------------------------------------
module tb_logic_clk_ctrl;
    import logic_clk_pkg::*;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic [1:0]    cmd_op = 2'b00;
    logic [W-1:0]  cmd_count = '0;
    logic          brk = 1'b0;

    logic          cmd_ready, clk_en, halted, step_done, brk_hit;
    logic [W-1:0]  cycle_cnt;
    logic          cmd_ready4, clk_en4, halted4, step_done4, brk_hit4;
    logic [3:0]    cycle_cnt4;

    logic_clk_ctrl #(.CNT_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_count(cmd_count), .brk(brk), .clk_en(clk_en),
        .halted(halted), .step_done(step_done), .brk_hit(brk_hit),
        .cycle_cnt(cycle_cnt)
    );

    logic_clk_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready4),
        .cmd_op(cmd_op), .cmd_count(cmd_count[3:0]), .brk(brk), .clk_en(clk_en4),
        .halted(halted4), .step_done(step_done4), .brk_hit(brk_hit4),
        .cycle_cnt(cycle_cnt4)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit halted;
        bit ready;
        bit done;
        bit hit;
        bit en;
        int cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;

    int checks = 0;
    int errors = 0;
    int pulses_seen = 0;
    int done_seen = 0;

    // Reference model state.
    int budget = 0;
    bit m_hit = 1'b0;
    bit m_open = 1'b0;     // gate open for the next rising edge
    int m_cnt = 0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Predict the outputs visible after one rising edge with these inputs.
    task automatic model_edge(input bit rst, input bit v, input logic [1:0] op,
                              input int n, input bit b, output exp_t e);
        bit pulse = m_open;
        bit done = 1'b0;
        if (rst) begin
            budget = 0;
            m_hit  = 1'b0;
            m_cnt  = 0;
        end else begin
            m_cnt = (m_cnt + int'(pulse)) % 65536;
            if (budget > 0) begin
                budget--;
                if (b) begin
                    budget = 0;
                    done   = 1'b1;
                    m_hit  = 1'b1;
                end else if (budget == 0) begin
                    done = 1'b1;
                end
            end else if (budget < 0 && b) begin
                budget = 0;
                m_hit  = 1'b1;
            end else if (v) begin
                if (op == OP_RUN || op == OP_STEP) m_hit = 1'b0;
                if (op == OP_RUN) budget = -1;
                else if (op == OP_HALT) budget = 0;
                else if (op == OP_STEP) begin
                    if (n > 0) budget = n;
                    else done = 1'b1;
                end
            end
        end
        m_open   = (budget != 0);
        e.halted = (budget == 0);
        e.ready  = (budget <= 0);
        e.done   = done;
        e.hit    = m_hit;
        e.en     = pulse;
        e.cnt    = m_cnt;
    endtask

    // Drive one cycle from just after a falling edge so the reset edge's
    // own gated pulse is preserved, as in a real mid-cycle reset.
    task automatic do_cycle(input bit rst, input bit v, input logic [1:0] op,
                            input int n, input bit b);
        exp_t e;
        rst_n     = !rst;
        cmd_valid = v;
        cmd_op    = op;
        cmd_count = W'(n);
        brk       = b;
        model_edge(rst, v, op, n, b, e);
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) do_cycle(1'b0, 1'b0, OP_NOP, 0, 1'b0);
    endtask

    // Monitor: compares every observed cycle against the scoreboard.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            check("halted", halted, cur.halted);
            check("cmd_ready", cmd_ready, cur.ready);
            check("step_done", step_done, cur.done);
            check("brk_hit", brk_hit, cur.hit);
            check("clk_en", clk_en, cur.en);
            check("cycle_cnt", cycle_cnt, cur.cnt);
            check("halted_w4", halted4, cur.halted);
            check("clk_en_w4", clk_en4, cur.en);
            check("cycle_cnt_w4", cycle_cnt4, cur.cnt % 16);
            if (clk_en) pulses_seen++;
            if (step_done) done_seen++;
        end
    end

    // The enable must only move while clk is low.
    always @(clk_en) begin
        check("clk_en_change_clk_low", clk, 0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0, d0;
        logic [1:0] op;
        int n;

        @(negedge clk);
        #1;
        do_cycle(1'b1, 1'b0, OP_NOP, 0, 1'b0);
        do_cycle(1'b1, 1'b0, OP_NOP, 0, 1'b0);

        // Reset then idle.
        idle(10);
        check("idle_clk_en", clk_en, 0);
        check("idle_halted", halted, 1);
        check("idle_ready", cmd_ready, 1);
        check("idle_cnt", cycle_cnt, 0);

        // STEP 5.
        p0 = pulses_seen; d0 = done_seen;
        do_cycle(1'b0, 1'b1, OP_STEP, 5, 1'b0);
        check("step5_ready_low", cmd_ready, 0);
        idle(7);
        check("step5_pulses", pulses_seen - p0, 5);
        check("step5_done_count", done_seen - d0, 1);
        check("step5_cnt", cycle_cnt, 5);

        // RUN 20 cycles then HALT: 21 pulses including the HALT edge.
        p0 = pulses_seen;
        do_cycle(1'b0, 1'b1, OP_RUN, 0, 1'b0);
        idle(20);
        do_cycle(1'b0, 1'b1, OP_HALT, 0, 1'b0);
        idle(3);
        check("run_halt_pulses", pulses_seen - p0, 21);
        check("run_halt_cnt", cycle_cnt, 26);

        // Breakpoint on the same edge as a STEP command while running.
        do_cycle(1'b0, 1'b1, OP_RUN, 0, 1'b0);
        idle(3);
        do_cycle(1'b0, 1'b1, OP_STEP, 4, 1'b1);
        check("brk_halted", halted, 1);
        check("brk_hit_set", brk_hit, 1);
        p0 = pulses_seen;
        idle(3);
        check("brk_step_dropped", pulses_seen - p0, 0);
        do_cycle(1'b0, 1'b1, OP_RUN, 0, 1'b0);
        check("brk_hit_cleared", brk_hit, 0);
        idle(2);
        do_cycle(1'b0, 1'b1, OP_HALT, 0, 1'b0);
        idle(2);

        // STEP 0.
        p0 = pulses_seen; d0 = done_seen;
        do_cycle(1'b0, 1'b1, OP_STEP, 0, 1'b0);
        idle(3);
        check("step0_pulses", pulses_seen - p0, 0);
        check("step0_done_count", done_seen - d0, 1);

        // 17 pulses wrap the 4-bit counter to 1.
        do_cycle(1'b1, 1'b0, OP_NOP, 0, 1'b0);
        do_cycle(1'b0, 1'b1, OP_RUN, 0, 1'b0);
        idle(16);
        do_cycle(1'b0, 1'b1, OP_HALT, 0, 1'b0);
        idle(2);
        check("wrap_cnt_w4", cycle_cnt4, 1);
        check("wrap_cnt_w16", cycle_cnt, 17);

        // Reset mid-STEP after 3 of 8 pulses; the reset edge pulse still
        // occurs, nothing after it.
        p0 = pulses_seen; d0 = done_seen;
        do_cycle(1'b0, 1'b1, OP_STEP, 8, 1'b0);
        idle(3);
        do_cycle(1'b1, 1'b0, OP_NOP, 0, 1'b0);
        do_cycle(1'b1, 1'b0, OP_NOP, 0, 1'b0);
        idle(4);
        check("rst_step_pulses", pulses_seen - p0, 4);
        check("rst_step_no_done", done_seen - d0, 0);
        check("rst_halted", halted, 1);
        check("rst_ready", cmd_ready, 1);
        check("rst_brk_hit", brk_hit, 0);
        check("rst_cnt", cycle_cnt, 0);
        check("rst_clk_en", clk_en, 0);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            op = 2'($urandom_range(0, 3));
            n  = int'($urandom_range(0, 12));
            if (budget < 0 && op == OP_STEP && n == 0) n = 1;
            do_cycle($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0,
                     op, n, $urandom_range(0, 11) == 0);
        end

        idle(3);
        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
